// File: rtl/mpeg_audio_pacer_if.sv
// Sample stream between the MPEG audio sample FIFO and its consumer.
//   write  : source has a valid sample on `sample`
//   strobe : sink is ready; a sample moves when write && strobe
//   sample : signed 16-bit PCM sample, valid while write is high
interface audiostream;
    logic               write;
    logic               strobe;
    logic signed [15:0] sample;

    modport sink   (input write, input sample, output strobe);
    modport source (output write, output sample, input strobe);
endinterface

// File: rtl/mpeg_audio_pacer.sv
// MPEG audio pacer: pulls PCM samples from the sample FIFO, assembles left/right pairs
// (mono duplicated, stereo interleaved L then R) and presents one pair per sample_tick.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   in               : audiostream sink (write/sample from FIFO, strobe driven here)
//   fifo_half_full   : FIFO has reached the start threshold
//   enable           : playback enable
//   stereo           : 1 = interleaved L,R; 0 = mono (latched while buffering)
//   sample_tick      : output sample-rate pulse
//   left, right      : registered output pair
//   sample_valid     : pulse the cycle after each sample_tick
//   playing          : high whenever not buffering
//   underrun_count   : saturating count of ticks that found no complete pair
module mpeg_audio_pacer #(
    parameter int unsigned UNDERRUN_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    audiostream.sink                  in,
    input  logic                      fifo_half_full,
    input  logic                      enable,
    input  logic                      stereo,
    input  logic                      sample_tick,
    output logic signed [15:0]        left,
    output logic signed [15:0]        right,
    output logic                      sample_valid,
    output logic                      playing,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

    typedef enum logic [1:0] {StBuffering, StFetchL, StFetchR, StReady} state_t;

    state_t                    state_q, state_d;
    logic                      mode_stereo_q, mode_stereo_d;
    logic signed [15:0]        pair_l_q, pair_l_d;
    logic signed [15:0]        pair_r_q, pair_r_d;
    logic signed [15:0]        left_d, right_d;
    logic [UNDERRUN_CNT_W-1:0] count_d;
    logic                      accept;
    logic                      starved;
    state_t                    after_tick;

    assign in.strobe = (state_q == StFetchL || state_q == StFetchR) && !reset;
    assign accept    = in.write && in.strobe;
    assign playing   = (state_q != StBuffering);
    // Where a serviced tick leads once the pair has been consumed.
    assign after_tick = enable ? StFetchL : StBuffering;

    always_comb begin
        state_d       = state_q;
        mode_stereo_d = (state_q == StBuffering) ? stereo : mode_stereo_q;
        pair_l_d      = pair_l_q;
        pair_r_d      = pair_r_q;
        left_d        = left;
        right_d       = right;
        starved       = 1'b0;

        case (state_q)
            StBuffering: begin
                if (enable && fifo_half_full) state_d = StFetchL;
                if (sample_tick) begin
                    left_d  = '0;
                    right_d = '0;
                end
            end
            StFetchL: begin
                if (accept) begin
                    pair_l_d = in.sample;
                    if (mode_stereo_q) begin
                        state_d = StFetchR;
                        starved = sample_tick;
                    end else begin
                        pair_r_d = in.sample;
                        if (sample_tick) begin
                            // Bypass: the completing sample goes straight out.
                            left_d  = in.sample;
                            right_d = in.sample;
                            state_d = after_tick;
                        end else begin
                            state_d = StReady;
                        end
                    end
                end else if (sample_tick) begin
                    // FIFO is empty here (strobe is high), so re-prime.
                    starved = 1'b1;
                    state_d = StBuffering;
                end else if (!enable) begin
                    state_d = StBuffering;
                end
            end
            StFetchR: begin
                // Enable is ignored so the R sample is never dropped.
                if (accept) begin
                    pair_r_d = in.sample;
                    if (sample_tick) begin
                        left_d  = pair_l_q;
                        right_d = in.sample;
                        state_d = after_tick;
                    end else begin
                        state_d = StReady;
                    end
                end else if (sample_tick) begin
                    starved = 1'b1;
                end
            end
            StReady: begin
                if (sample_tick) begin
                    left_d  = pair_l_q;
                    right_d = pair_r_q;
                    state_d = after_tick;
                end
            end
            default: state_d = StBuffering;
        endcase

        if (starved) begin
            left_d  = '0;
            right_d = '0;
        end

        count_d = underrun_count;
        if (starved && (underrun_count != '1)) begin
            count_d = underrun_count + UNDERRUN_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StBuffering;
            mode_stereo_q  <= 1'b0;
            pair_l_q       <= '0;
            pair_r_q       <= '0;
            left           <= '0;
            right          <= '0;
            sample_valid   <= 1'b0;
            underrun_count <= '0;
        end else begin
            state_q        <= state_d;
            mode_stereo_q  <= mode_stereo_d;
            pair_l_q       <= pair_l_d;
            pair_r_q       <= pair_r_d;
            left           <= left_d;
            right          <= right_d;
            sample_valid   <= sample_tick;
            underrun_count <= count_d;
        end
    end

endmodule

// File: tb/tb_mpeg_audio_pacer.sv
// Self-checking bench for mpeg_audio_pacer: directed scenarios plus a randomized phase,
// all compared every cycle against a behavioural pair-assembly model.
module tb_mpeg_audio_pacer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_half_full;
    logic        enable;
    logic        stereo;
    logic        sample_tick;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample_valid;
    logic        playing;
    logic [7:0]  underrun_count;

    always #5 clk = ~clk;

    audiostream bus ();

    // FIFO source model: circular buffer, written by stimulus, popped on handshake.
    logic [15:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.write  = (wr_ptr != rd_ptr);
    assign bus.sample = mem[rd_ptr[9:0]];

    mpeg_audio_pacer #(.UNDERRUN_CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in             (bus),
        .fifo_half_full (fifo_half_full),
        .enable         (enable),
        .stereo         (stereo),
        .sample_tick    (sample_tick),
        .left           (left),
        .right          (right),
        .sample_valid   (sample_valid),
        .playing        (playing),
        .underrun_count (underrun_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: is playback running, is a pair complete, is an L waiting for its R.
    bit          m_run, m_full, m_want_r, m_stereo, m_v;
    logic [15:0] m_pl, m_pr, m_l, m_r;
    int          m_cnt;
    logic [31:0] log_q [$];

    always @(posedge clk) begin
        bit          rs, tk, acc, completes;
        logic [15:0] s;
        rs  = reset;
        tk  = sample_tick;
        s   = bus.sample;
        acc = !rs && m_run && !m_full && bus.write;
        completes = acc && (m_want_r || !m_stereo);
        if (rs) begin
            m_run = 0; m_full = 0; m_want_r = 0; m_stereo = 0; m_v = 0;
            m_pl = 0; m_pr = 0; m_l = 0; m_r = 0; m_cnt = 0;
        end else begin
            m_v = tk;
            if (tk) begin
                if (!m_run) begin
                    m_l = 0; m_r = 0;
                end else if (m_full) begin
                    m_l = m_pl; m_r = m_pr;
                end else if (completes) begin
                    m_l = m_want_r ? m_pl : s;
                    m_r = s;
                end else begin
                    m_l = 0; m_r = 0;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (!m_run) begin
                m_stereo = stereo;
                if (enable && fifo_half_full) m_run = 1;
            end else if (m_full) begin
                if (tk) begin
                    m_full = 0;
                    m_run  = enable;
                end
            end else if (acc) begin
                if (!m_want_r && m_stereo) begin
                    m_pl = s;
                    m_want_r = 1;
                end else begin
                    if (!m_want_r) m_pl = s;
                    m_pr = s;
                    m_want_r = 0;
                    if (tk) m_run = enable;
                    else m_full = 1;
                end
            end else if (!m_want_r) begin
                if (tk || !enable) m_run = 0;
            end
        end
        #1;
        if (acc) rd_ptr++;
        check("sample_valid", 32'(sample_valid), 32'(m_v));
        check("left", 32'(left), 32'(m_l));
        check("right", 32'(right), 32'(m_r));
        check("playing", 32'(playing), 32'(m_run));
        check("underrun_count", 32'(underrun_count), 32'(m_cnt));
        check("strobe", 32'(bus.strobe), 32'(m_run && !m_full && !reset));
        if (sample_valid) log_q.push_back({left, right});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr++;
    endtask

    task automatic tick_pulse;
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        enable = 1'b0;
        fifo_half_full = 1'b0;
        sample_tick = 1'b0;
        wr_ptr = rd_ptr;
        cyc(2);
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        if (idx < log_q.size()) check(name, log_q[idx], exp);
        else check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; stereo = 1'b0; fifo_half_full = 1'b0; sample_tick = 1'b0;
        cyc(3);
        check("reset_left", 32'(left), 32'h0);
        check("reset_strobe", 32'(bus.strobe), 32'h0);
        check("reset_count", 32'(underrun_count), 32'h0);

        // Mono prime
        do_reset;
        stereo = 1'b0;
        for (int i = 0; i < 70; i++) push(16'h0100 + 16'(i));
        fifo_half_full = 1'b1; enable = 1'b1;
        repeat (10) begin cyc(19); tick_pulse; end
        cyc(3);
        check("mono_log_size", 32'(log_q.size()), 32'd10);
        check_log("mono_pair0", 0, 32'h0100_0100);
        check_log("mono_pair1", 1, 32'h0101_0101);
        check_log("mono_pair9", 9, 32'h0109_0109);
        check("mono_count", 32'(underrun_count), 32'h0);

        // Stereo interleave
        do_reset;
        stereo = 1'b1;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(9); tick_pulse; cyc(9); tick_pulse; cyc(3);
        check_log("stereo_pair0", 0, 32'h1111_2222);
        check_log("stereo_pair1", 1, 32'h3333_4444);

        // Underrun while waiting for R
        do_reset;
        stereo = 1'b1;
        push(16'h7FFF);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(5); tick_pulse; cyc(2);
        check_log("fetchr_underrun_out", 0, 32'h0);
        check("fetchr_underrun_count", 32'(underrun_count), 32'd1);
        check("fetchr_still_fetching", 32'(bus.strobe), 32'h1);
        push(16'h8000);
        cyc(3); tick_pulse; cyc(2);
        check_log("fetchr_late_pair", 1, 32'h7FFF_8000);

        // Starvation re-prime
        do_reset;
        stereo = 1'b0;
        push(16'h0A0A); push(16'h0B0B);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(5); tick_pulse; cyc(3); tick_pulse; cyc(3);
        fifo_half_full = 1'b0;
        tick_pulse; cyc(2);
        check_log("starve_out", 2, 32'h0);
        check("starve_count", 32'(underrun_count), 32'd1);
        check("starve_playing", 32'(playing), 32'h0);
        tick_pulse; cyc(3); tick_pulse; cyc(3);
        check("buffering_no_count", 32'(underrun_count), 32'd1);
        check_log("buffering_out", 4, 32'h0);
        push(16'h0C0C);
        cyc(3);
        check("buffering_no_strobe", 32'(bus.strobe), 32'h0);
        fifo_half_full = 1'b1;
        cyc(4); tick_pulse; cyc(2);
        check_log("reprime_pair", 5, 32'h0C0C_0C0C);

        // Bypass: tick in the same cycle as the R accept
        do_reset;
        stereo = 1'b1;
        push(16'h1234);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(5);
        push(16'h5A5A);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(2);
        check_log("bypass_pair", 0, 32'h1234_5A5A);
        check("bypass_count", 32'(underrun_count), 32'h0);

        // Saturation after 300 starved ticks
        do_reset;
        stereo = 1'b0;
        fifo_half_full = 1'b1; enable = 1'b1;
        repeat (300) begin cyc(2); tick_pulse; end
        cyc(2);
        check("saturate_count", 32'(underrun_count), 32'd255);

        // Enable dropped while waiting for R
        do_reset;
        stereo = 1'b1;
        push(16'hAAAA);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(4);
        enable = 1'b0;
        cyc(3);
        check("disable_fetchr_strobe", 32'(bus.strobe), 32'h1);
        push(16'hBBBB);
        cyc(3);
        check("disable_ready_playing", 32'(playing), 32'h1);
        tick_pulse; cyc(2);
        check_log("disable_pair", 0, 32'hAAAA_BBBB);
        check("disable_buffering", 32'(playing), 32'h0);

        // Reset in the middle of a stereo pair
        do_reset;
        stereo = 1'b1;
        push(16'hCCCC);
        fifo_half_full = 1'b1; enable = 1'b1;
        cyc(4); tick_pulse; cyc(1);
        check("pre_reset_count", 32'(underrun_count), 32'd1);
        reset = 1'b1;
        cyc(1);
        check("midreset_strobe", 32'(bus.strobe), 32'h0);
        check("midreset_count", 32'(underrun_count), 32'h0);
        check("midreset_pair", {left, right}, 32'h0);
        reset = 1'b0;

        // Randomized phase
        do_reset;
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            sample_tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) stereo = ~stereo;
            if ($urandom_range(0, 7) == 0) fifo_half_full = ~fifo_half_full;
            if ((wr_ptr - rd_ptr) < 500 && $urandom_range(0, 2) == 0) push(16'($urandom));
            cyc(1);
        end
        reset = 1'b0;
        sample_tick = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
